// File: rtl/arp_rx_multi.sv
// ARP frame receiver on a GMII byte stream. It checks the preamble, the
// destination MAC, an optional 802.1Q tag and the ARP header. It matches the
// target IP against a list of local addresses. On a valid frame it reports the
// sender and the index of the matching local IP.
module arp_rx_multi #(
   parameter logic [47:0]          BOARD_MAC     = 48'h00_11_22_33_44_55,
   parameter int                   IP_NUM        = 2,
   parameter logic [IP_NUM*32-1:0] BOARD_IP_LIST = {8'd192, 8'd168, 8'd1, 8'd11,
                                                    8'd192, 8'd168, 8'd1, 8'd10},
   parameter bit                   VLAN_EN       = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        gmii_rx_dv,
   input  logic [7:0]  gmii_rxd,
   output logic        arp_rx_done,
   output logic        arp_rx_type,
   output logic [47:0] src_mac,
   output logic [31:0] src_ip,
   output logic [1:0]  ip_hit_idx,
   output logic [11:0] vlan_id,
   output logic [15:0] drop_cnt
);

   typedef enum logic [2:0] {
      IDLE, PREAMBLE, ETH_HEAD, VLAN_TAG, ARP_DATA, RX_END
   } state_t;

   state_t      state, state_n;
   logic [4:0]  cnt;        // byte index inside the current state
   logic        mac_ok;     // destination so far equals BOARD_MAC
   logic        bc_ok;      // destination so far equals broadcast
   logic [7:0]  prev_byte;  // previous byte, used for the EtherType check
   logic [11:0] vid_sh;
   logic [47:0] smac_sh;
   logic [31:0] sip_sh;
   logic [23:0] tip_sh;
   logic        reply;
   logic        accept, reject;
   logic [7:0]  mac_byte;
   logic        mac_ok_n, bc_ok_n;
   logic        hit;
   logic [1:0]  hit_idx;

   // Select the BOARD_MAC byte that is expected at the current header position
   always_comb begin
      case (cnt[2:0])
         3'd0:    mac_byte = BOARD_MAC[47:40];
         3'd1:    mac_byte = BOARD_MAC[39:32];
         3'd2:    mac_byte = BOARD_MAC[31:24];
         3'd3:    mac_byte = BOARD_MAC[23:16];
         3'd4:    mac_byte = BOARD_MAC[15:8];
         default: mac_byte = BOARD_MAC[7:0];
      endcase
   end

   assign mac_ok_n = mac_ok && (gmii_rxd == mac_byte);
   assign bc_ok_n  = bc_ok  && (gmii_rxd == 8'hFF);

   // Compare the full target IP with every local entry; the lowest index wins
   always_comb begin
      hit     = 1'b0;
      hit_idx = 2'd0;
      for (int i = IP_NUM - 1; i >= 0; i--) begin
         if ({tip_sh, gmii_rxd} == BOARD_IP_LIST[32*i +: 32]) begin
            hit     = 1'b1;
            hit_idx = 2'(i);
         end
      end
   end

   // Next-state logic with the accept and reject decisions for the current byte
   always_comb begin
      // NOTE: every output of this block gets a default first, so no latch is inferred.
      state_n = state;
      accept  = 1'b0;
      reject  = 1'b0;
      case (state)
         IDLE: begin
            if (gmii_rx_dv && gmii_rxd == 8'h55) state_n = PREAMBLE;
         end
         PREAMBLE: begin
            if (!gmii_rx_dv) begin
               state_n = IDLE;
            end else if (cnt < 5'd6) begin
               if (gmii_rxd != 8'h55) state_n = RX_END;
            end else begin
               state_n = (gmii_rxd == 8'hD5) ? ETH_HEAD : RX_END;
            end
         end
         ETH_HEAD: begin
            if (!gmii_rx_dv) begin
               reject  = 1'b1;
               state_n = IDLE;
            end else if (cnt < 5'd6) begin
               if (!mac_ok_n && !bc_ok_n) begin
                  reject  = 1'b1;
                  state_n = RX_END;
               end
            end else if (cnt == 5'd13) begin
               if ({prev_byte, gmii_rxd} == 16'h0806) begin
                  state_n = ARP_DATA;
               end else if (VLAN_EN && {prev_byte, gmii_rxd} == 16'h8100) begin
                  state_n = VLAN_TAG;
               end else begin
                  reject  = 1'b1;
                  state_n = RX_END;
               end
            end
         end
         VLAN_TAG: begin
            if (!gmii_rx_dv) begin
               reject  = 1'b1;
               state_n = IDLE;
            end else if ((cnt == 5'd2 && gmii_rxd != 8'h08) ||
                         (cnt == 5'd3 && gmii_rxd != 8'h06)) begin
               reject  = 1'b1;
               state_n = RX_END;
            end else if (cnt == 5'd3) begin
               state_n = ARP_DATA;
            end
         end
         ARP_DATA: begin
            if (!gmii_rx_dv) begin
               reject  = 1'b1;
               state_n = IDLE;
            end else begin
               case (cnt)
                  5'd0:    reject = (gmii_rxd != 8'h00);
                  5'd1:    reject = (gmii_rxd != 8'h01);
                  5'd2:    reject = (gmii_rxd != 8'h08);
                  5'd3:    reject = (gmii_rxd != 8'h00);
                  5'd4:    reject = (gmii_rxd != 8'h06);
                  5'd5:    reject = (gmii_rxd != 8'h04);
                  5'd6:    reject = (gmii_rxd != 8'h00);
                  5'd7:    reject = (gmii_rxd != 8'h01 && gmii_rxd != 8'h02);
                  5'd27: begin
                     accept = hit;
                     reject = !hit;
                  end
                  default: reject = 1'b0;
               endcase
               if (reject || accept) state_n = RX_END;
            end
         end
         RX_END: begin
            if (!gmii_rx_dv) state_n = IDLE;
         end
         default: state_n = RX_END;
      endcase
   end

   // State register; reset parks in RX_END so a frame already in flight is discarded
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RX_END;
      else     state <= state_n;
   end

   // Byte counter, header flags and field shift registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         mac_ok    <= 1'b0;
         bc_ok     <= 1'b0;
         prev_byte <= '0;
         vid_sh    <= '0;
         smac_sh   <= '0;
         sip_sh    <= '0;
         tip_sh    <= '0;
         reply     <= 1'b0;
      end else begin
         if (state_n != state)  cnt <= '0;
         else if (gmii_rx_dv)   cnt <= cnt + 5'd1;
         if (gmii_rx_dv) prev_byte <= gmii_rxd;
         if (state == PREAMBLE && state_n == ETH_HEAD) begin
            mac_ok <= 1'b1;
            bc_ok  <= 1'b1;
            vid_sh <= '0;
         end
         if (state == ETH_HEAD && gmii_rx_dv && cnt < 5'd6) begin
            mac_ok <= mac_ok_n;
            bc_ok  <= bc_ok_n;
         end
         if (state == VLAN_TAG && gmii_rx_dv) begin
            if (cnt == 5'd0) vid_sh[11:8] <= gmii_rxd[3:0];
            if (cnt == 5'd1) vid_sh[7:0]  <= gmii_rxd;
         end
         if (state == ARP_DATA && gmii_rx_dv) begin
            if (cnt == 5'd7)                  reply   <= (gmii_rxd == 8'h02);
            if (cnt >= 5'd8  && cnt <= 5'd13) smac_sh <= {smac_sh[39:0], gmii_rxd};
            if (cnt >= 5'd14 && cnt <= 5'd17) sip_sh  <= {sip_sh[23:0], gmii_rxd};
            if (cnt >= 5'd24 && cnt <= 5'd26) tip_sh  <= {tip_sh[15:0], gmii_rxd};
         end
      end
   end

   // Output registers: the done pulse, the held results and the saturating drop counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arp_rx_done <= 1'b0;
         arp_rx_type <= 1'b0;
         src_mac     <= '0;
         src_ip      <= '0;
         ip_hit_idx  <= '0;
         vlan_id     <= '0;
         drop_cnt    <= '0;
      end else begin
         arp_rx_done <= accept;
         if (accept) begin
            arp_rx_type <= reply;
            src_mac     <= smac_sh;
            src_ip      <= sip_sh;
            ip_hit_idx  <= hit_idx;
            vlan_id     <= vid_sh;
         end
         if (reject && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_arp_rx_multi.sv
// Directed bench for arp_rx_multi. Frames are built byte by byte, and every
// expected value is written by hand from the frame contents.
module tb_arp_rx_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic        gmii_rx_dv;
   logic [7:0]  gmii_rxd;
   logic        arp_rx_done;
   logic        arp_rx_type;
   logic [47:0] src_mac;
   logic [31:0] src_ip;
   logic [1:0]  ip_hit_idx;
   logic [11:0] vlan_id;
   logic [15:0] drop_cnt;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   int done_at;
   int d0;
   logic [7:0] frm [$];

   localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
   localparam logic [47:0] BMAC  = 48'h00_11_22_33_44_55;

   arp_rx_multi dut (
      .clk         (clk),
      .rst         (rst),
      .gmii_rx_dv  (gmii_rx_dv),
      .gmii_rxd    (gmii_rxd),
      .arp_rx_done (arp_rx_done),
      .arp_rx_type (arp_rx_type),
      .src_mac     (src_mac),
      .src_ip      (src_ip),
      .ip_hit_idx  (ip_hit_idx),
      .vlan_id     (vlan_id),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   // Count the cycles in which the done pulse is high
   always @(negedge clk) if (arp_rx_done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic build(input logic [47:0] dst, input logic vlan, input logic [15:0] tci,
                        input logic [15:0] oper, input logic [47:0] smac,
                        input logic [31:0] sip, input logic [31:0] tip);
      frm.delete();
      repeat (7) frm.push_back(8'h55);
      frm.push_back(8'hD5);
      for (int i = 5; i >= 0; i--) frm.push_back(dst[8*i +: 8]);
      repeat (6) frm.push_back(8'h66);
      if (vlan) begin
         frm.push_back(8'h81); frm.push_back(8'h00);
         frm.push_back(tci[15:8]); frm.push_back(tci[7:0]);
      end
      frm.push_back(8'h08); frm.push_back(8'h06);
      frm.push_back(8'h00); frm.push_back(8'h01);
      frm.push_back(8'h08); frm.push_back(8'h00);
      frm.push_back(8'h06); frm.push_back(8'h04);
      frm.push_back(oper[15:8]); frm.push_back(oper[7:0]);
      for (int i = 5; i >= 0; i--) frm.push_back(smac[8*i +: 8]);
      for (int i = 3; i >= 0; i--) frm.push_back(sip[8*i +: 8]);
      repeat (6) frm.push_back(8'h00);
      for (int i = 3; i >= 0; i--) frm.push_back(tip[8*i +: 8]);
      repeat (4) frm.push_back(8'hA5);
   endtask

   // Drive the first n bytes of frm, then dv low for three cycles.
   // done_at records how many bytes had been driven when done was first seen.
   task automatic send(input int n);
      done_at = -1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (arp_rx_done === 1'b1 && done_at < 0) done_at = i;
         gmii_rx_dv = 1'b1;
         gmii_rxd   = frm[i];
      end
      @(negedge clk);
      if (arp_rx_done === 1'b1 && done_at < 0) done_at = n;
      gmii_rx_dv = 1'b0;
      gmii_rxd   = 8'h00;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_out(input string tag, input logic typ, input logic [47:0] mac,
                            input logic [31:0] ip, input logic [1:0] idx, input logic [11:0] vid,
                            input logic [15:0] drops);
      check({tag, " type"}, 64'(arp_rx_type), 64'(typ));
      check({tag, " src_mac"}, 64'(src_mac), 64'(mac));
      check({tag, " src_ip"}, 64'(src_ip), 64'(ip));
      check({tag, " idx"}, 64'(ip_hit_idx), 64'(idx));
      check({tag, " vlan"}, 64'(vlan_id), 64'(vid));
      check({tag, " drops"}, 64'(drop_cnt), 64'(drops));
   endtask

   initial begin
      rst        = 1'b1;
      gmii_rx_dv = 1'b0;
      gmii_rxd   = 8'h00;
      repeat (3) @(negedge clk);
      check("reset done", 64'(arp_rx_done), 64'd0);
      check_out("reset", 1'b0, 48'd0, 32'd0, 2'd0, 12'd0, 16'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Broadcast request for 192.168.1.10
      build(BCAST, 1'b0, 16'h0, 16'd1, 48'h00_AA_BB_CC_DD_EE, 32'hC0A80102, 32'hC0A8010A);
      d0 = done_cnt;
      send(frm.size());
      check("bcast pulses", 64'(done_cnt - d0), 64'd1);
      check("bcast timing", 64'(done_at), 64'd50);
      check_out("bcast", 1'b0, 48'h00_AA_BB_CC_DD_EE, 32'hC0A80102, 2'd0, 12'd0, 16'd0);

      // Tagged unicast reply for 192.168.1.11
      build(BMAC, 1'b1, 16'h0064, 16'd2, 48'h02_12_34_56_78_9A, 32'hC0A80103, 32'hC0A8010B);
      d0 = done_cnt;
      send(frm.size());
      check("vlan pulses", 64'(done_cnt - d0), 64'd1);
      check("vlan timing", 64'(done_at), 64'd54);
      check_out("vlan", 1'b1, 48'h02_12_34_56_78_9A, 32'hC0A80103, 2'd1, 12'h064, 16'd0);

      // Priority bits of the TCI are not part of the VID
      build(BCAST, 1'b1, 16'hE123, 16'd1, 48'h0A_0B_0C_0D_0E_0F, 32'h0A000001, 32'hC0A8010A);
      d0 = done_cnt;
      send(frm.size());
      check("pcp pulses", 64'(done_cnt - d0), 64'd1);
      check_out("pcp", 1'b0, 48'h0A_0B_0C_0D_0E_0F, 32'h0A000001, 2'd0, 12'h123, 16'd0);

      // Three rejects: unknown target IP, OPER=3, wrong destination MAC
      d0 = done_cnt;
      build(BCAST, 1'b0, 16'h0, 16'd1, 48'h11_11_11_11_11_11, 32'h01010101, 32'hC0A80163);
      send(frm.size());
      check("rej ip drops", 64'(drop_cnt), 64'd1);
      build(BCAST, 1'b0, 16'h0, 16'd3, 48'h11_11_11_11_11_11, 32'h01010101, 32'hC0A8010A);
      send(frm.size());
      check("rej oper drops", 64'(drop_cnt), 64'd2);
      build(48'h00_11_22_33_44_56, 1'b0, 16'h0, 16'd1, 48'h11_11_11_11_11_11, 32'h01010101,
            32'hC0A8010A);
      send(frm.size());
      check("rej pulses", 64'(done_cnt - d0), 64'd0);
      check_out("rej", 1'b0, 48'h0A_0B_0C_0D_0E_0F, 32'h0A000001, 2'd0, 12'h123, 16'd3);

      // Non-ARP EtherType is rejected
      build(BCAST, 1'b0, 16'h0, 16'd1, 48'h11_11_11_11_11_11, 32'h01010101, 32'hC0A8010A);
      frm[21] = 8'h00;
      send(frm.size());
      check("ethtype drops", 64'(drop_cnt), 64'd4);

      // Broken preamble is silently dropped, and the next frame is accepted
      frm.delete();
      frm.push_back(8'h55); frm.push_back(8'h55); frm.push_back(8'h55);
      frm.push_back(8'h12); frm.push_back(8'h55); frm.push_back(8'hD5);
      d0 = done_cnt;
      send(frm.size());
      check("pre drops", 64'(drop_cnt), 64'd4);
      build(BCAST, 1'b0, 16'h0, 16'd2, 48'h00_01_02_03_04_05, 32'hC0A80104, 32'hC0A8010B);
      send(frm.size());
      check("pre next pulses", 64'(done_cnt - d0), 64'd1);
      check_out("pre next", 1'b1, 48'h00_01_02_03_04_05, 32'hC0A80104, 2'd1, 12'd0, 16'd4);

      // dv dropped after ARP byte 20: truncation counts as a reject
      build(BCAST, 1'b0, 16'h0, 16'd1, 48'h21_22_23_24_25_26, 32'hC0A80105, 32'hC0A8010A);
      d0 = done_cnt;
      send(8 + 14 + 21);
      check("trunc pulses", 64'(done_cnt - d0), 64'd0);
      check_out("trunc", 1'b1, 48'h00_01_02_03_04_05, 32'hC0A80104, 2'd1, 12'd0, 16'd5);
      send(frm.size());
      check("trunc next pulses", 64'(done_cnt - d0), 64'd1);
      check("trunc next mac", 64'(src_mac), 64'h21_22_23_24_25_26);

      // Reset pulse at ARP byte 10 with dv held high
      build(BCAST, 1'b0, 16'h0, 16'd1, 48'h31_32_33_34_35_36, 32'hC0A80106, 32'hC0A8010A);
      d0 = done_cnt;
      for (int i = 0; i < 33; i++) begin
         @(negedge clk);
         gmii_rx_dv = 1'b1;
         gmii_rxd   = frm[i];
      end
      @(negedge clk);
      rst      = 1'b1;
      gmii_rxd = frm[33];
      #1;
      check_out("rst mid", 1'b0, 48'd0, 32'd0, 2'd0, 12'd0, 16'd0);
      for (int i = 34; i < frm.size(); i++) begin
         @(negedge clk);
         rst      = 1'b0;
         gmii_rxd = frm[i];
      end
      @(negedge clk);
      gmii_rx_dv = 1'b0;
      repeat (3) @(negedge clk);
      check("rst pulses", 64'(done_cnt - d0), 64'd0);
      check_out("rst after", 1'b0, 48'd0, 32'd0, 2'd0, 12'd0, 16'd0);
      send(frm.size());
      check("rst fresh pulses", 64'(done_cnt - d0), 64'd1);
      check("rst fresh ip", 64'(src_ip), 64'hC0A80106);

      // Saturation of the drop counter
      @(negedge clk);
      force dut.drop_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.drop_cnt;
      @(negedge clk);
      check("sat preset", 64'(drop_cnt), 64'hFFFF);
      build(BCAST, 1'b0, 16'h0, 16'd1, 48'h11_11_11_11_11_11, 32'h01010101, 32'hC0A80163);
      send(frm.size());
      check("sat drops", 64'(drop_cnt), 64'hFFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/arp_rx_multi.md
ARP_RX_MULTI -- requirements
Module: arp_rx_multi

Interface
REQ-001 The block SHALL have parameter BOARD_MAC, default 48'h00_11_22_33_44_55, meaning the local MAC accepted as destination.
REQ-002 The block SHALL have parameter IP_NUM, default 2, range 1..4, meaning the number of local IPv4 addresses.
REQ-003 The block SHALL have parameter BOARD_IP_LIST, default {8'd192,8'd168,8'd1,8'd11, 8'd192,8'd168,8'd1,8'd10}, meaning IP_NUM*32 bits with entry i at bits [32i+31:32i].
REQ-004 The block SHALL have parameter VLAN_EN, default 1, meaning that a single 802.1Q tag is accepted when the value is 1.
REQ-005 The block SHALL have these ports (one clock; reset is asynchronous and active-high):
 clk  in  1  GMII receive clock, all logic on rising edge
 rst  in  1  asynchronous active-high reset
 gmii_rx_dv  in  1  receive data valid
 gmii_rxd  in  8  receive data byte
 arp_rx_done  out  1  one-cycle pulse, valid ARP accepted
 arp_rx_type  out  1  0 = request, 1 = reply
 src_mac  out  48  sender hardware address
 src_ip  out  32  sender protocol address
 ip_hit_idx  out  2  index of matched BOARD_IP_LIST entry
 vlan_id  out  12  VID of accepted frame, 0 if untagged
 drop_cnt  out  16  saturating count of rejected frames

Function
REQ-006 The FSM SHALL have the states IDLE, PREAMBLE, ETH_HEAD, VLAN_TAG, ARP_DATA and RX_END; a byte is consumed only on a cycle where gmii_rx_dv=1.
REQ-007 IDLE SHALL go to PREAMBLE when it receives a byte equal to 0x55.
REQ-008 PREAMBLE SHALL require 6 further 0x55 bytes followed by 0xD5, then go to ETH_HEAD; any other byte SHALL go to RX_END without a drop_cnt increment.
REQ-009 ETH_HEAD bytes 0-5 (destination MAC) SHALL equal BOARD_MAC or FF:FF:FF:FF:FF:FF, otherwise the frame is rejected.
REQ-010 ETH_HEAD bytes 12-13 (EtherType) SHALL be handled as follows:
 0x0806 -> ARP_DATA
 0x8100 with VLAN_EN=1 -> VLAN_TAG
 anything else -> reject
REQ-011 VLAN_TAG SHALL consume 4 bytes: TCI[11:0] is captured as the VID, and bytes 2-3 must equal 0x0806 (-> ARP_DATA), otherwise the frame is rejected.
REQ-012 ARP_DATA SHALL check the following fields, and any mismatch rejects the frame:
 bytes 0-1 HTYPE = 0x0001
 bytes 2-3 PTYPE = 0x0800
 byte 4 = 6
 byte 5 = 4
 bytes 6-7 OPER = 1 or 2
REQ-013 ARP_DATA SHALL capture bytes 8-13 as the sender MAC, bytes 14-17 as the sender IP, and bytes 24-27 as the target IP.
REQ-014 The target IP SHALL be compared against all IP_NUM entries in parallel; the lowest matching index wins, and no match rejects the frame.
REQ-015 On acceptance, arp_rx_done SHALL pulse high for exactly 1 cycle, the cycle after ARP byte 27 is sampled, and the block then goes to RX_END.
REQ-016 On acceptance, src_mac, src_ip, arp_rx_type, ip_hit_idx and vlan_id SHALL update on the same edge that raises arp_rx_done and SHALL hold until the next acceptance.
REQ-017 Rejected frames SHALL NOT change any data output.
REQ-018 gmii_rx_dv falling while in ETH_HEAD, VLAN_TAG or ARP_DATA SHALL count as a truncation reject -> IDLE.
REQ-019 A reject SHALL increment drop_cnt by 1, saturating at 0xFFFF; a reject is any rejection from ETH_HEAD, VLAN_TAG or ARP_DATA, including truncation.
REQ-020 RX_END SHALL ignore all bytes, including padding and FCS, and SHALL return to IDLE on the first cycle with gmii_rx_dv=0.
REQ-021 IDLE SHALL be held for at least 1 cycle between frames.
REQ-022 With IP_NUM=1, ip_hit_idx SHALL always be 0.

Reset
REQ-023 While rst=1, all outputs, counters and shift registers SHALL be 0.
REQ-024 After rst deasserts, the FSM SHALL start in RX_END, so that a frame already in progress is discarded until gmii_rx_dv=0.
REQ-025 rst asserted mid-frame SHALL abort the frame immediately with no arp_rx_done and no drop_cnt change.

Verification
REQ-026 Broadcast ARP request, OPER=1, sender 00-AA-BB-CC-DD-EE/192.168.1.2, target 192.168.1.10 -> done pulse of 1 cycle, type=0, ip_hit_idx=0, src_ip=C0A80102, vlan_id=0.
REQ-027 Unicast reply to BOARD_MAC, OPER=2, inside tag 0x8100 TCI=0x0064, target 192.168.1.11 -> done, type=1, ip_hit_idx=1, vlan_id=0x064.
REQ-028 Frames with, respectively, target 192.168.1.99, OPER=3, and destination MAC 00-11-22-33-44-56 -> no done, drop_cnt increases 0 -> 3, outputs unchanged.
REQ-029 Preamble 0x55 x3 then 0x12 -> RX_END, drop_cnt unchanged; a valid frame immediately following after dv low is accepted.
REQ-030 gmii_rx_dv dropped after ARP byte 20 -> drop_cnt +1, no done, next frame accepted; with drop_cnt forced to 0xFFFF, a further reject leaves it at 0xFFFF.
REQ-031 rst pulse at ARP byte 10 with dv held high -> outputs 0, remaining bytes ignored, no done until a fresh frame after dv low.
